// File: rtl/expr_pkg.sv
// Shared definitions for the expression serialiser: FSM encoding and ASCII constants.
package expr_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StDig  = 2'd1,
    StOp   = 2'd2,
    StFin  = 2'd3
  } state_e;

  localparam logic [7:0] CH_ZERO = 8'h30;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_STAR = 8'h2A;

endpackage

// File: rtl/expr_char_enc.sv
// Combinational ASCII encoder for one expression character (BCD digit or operator).
module expr_char_enc
  import expr_pkg::*;
(
  input  logic       is_op_i,
  input  logic       op_bit_i,
  input  logic [3:0] digit_i,
  output logic [7:0] ch_o
);

  always_comb begin
    if (is_op_i) begin
      ch_o = op_bit_i ? CH_STAR : CH_PLUS;
    end else begin
      ch_o = CH_ZERO + {4'h0, digit_i};
    end
  end

endmodule

// File: rtl/expr_tx.sv
// Serialises n BCD operands and n-1 operators as an ASCII infix expression over valid/ready.
module expr_tx
  import expr_pkg::*;
#(
  parameter int unsigned MAXN = 8
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  start,
  input  logic [3:0]            cnt,
  input  logic [4*MAXN-1:0]     digits,
  input  logic [MAXN-2:0]       ops,
  input  logic                  ready,
  output logic [7:0]            out,
  output logic                  valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  state_e              state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic [3:0]          cnt_q;
  logic [4*MAXN-1:0]   digits_q;
  logic [MAXN-2:0]     ops_q;
  logic                err_q, err_d;
  logic                load;
  logic                bad_start;
  logic                last;
  logic [31:0]         dig_pad;
  logic [7:0]          ops_pad;
  logic [3:0]          cur_digit;
  logic                cur_op;
  logic [7:0]          enc_ch;

  always_comb begin
    bad_start = (cnt == 4'd0) || (cnt > 4'(MAXN));
    for (int i = 0; i < int'(MAXN); i++) begin
      if ((4'(i) < cnt) && (digits[4*i +: 4] > 4'd9)) begin
        bad_start = 1'b1;
      end
    end
  end

  // Zero-pad captured operands to full 8-slot width so a 3-bit idx always selects in range.
  always_comb begin
    dig_pad = '0;
    dig_pad[4*MAXN-1:0] = digits_q;
    ops_pad = '0;
    ops_pad[MAXN-2:0] = ops_q;
  end

  assign cur_digit = dig_pad[{idx_q, 2'b00} +: 4];
  assign cur_op    = ops_pad[idx_q - 3'd1];
  assign last      = ({1'b0, idx_q} == (cnt_q - 4'd1));

  expr_char_enc u_enc (
    .is_op_i  (state_q == StOp),
    .op_bit_i (cur_op),
    .digit_i  (cur_digit),
    .ch_o     (enc_ch)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (bad_start) begin
            err_d = 1'b1;
          end else begin
            load    = 1'b1;
            idx_d   = 3'd0;
            state_d = StDig;
          end
        end
      end
      StDig: begin
        if (ready) begin
          if (last) begin
            state_d = StFin;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = StOp;
          end
        end
      end
      StOp: begin
        if (ready) begin
          state_d = StDig;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= StIdle;
      idx_q   <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q    <= 4'd0;
      digits_q <= '0;
      ops_q    <= '0;
    end else if (load) begin
      cnt_q    <= cnt;
      digits_q <= digits;
      ops_q    <= ops;
    end
  end

  assign valid = (state_q == StDig) || (state_q == StOp);
  assign out   = valid ? enc_ch : 8'h00;
  assign busy  = (state_q != StIdle);
  assign done  = (state_q == StFin);
  assign err   = err_q;

endmodule

// File: tb/tb_expr_tx.sv
// Scoreboard bench for expr_tx: stimulus queues expected characters, a monitor checks the stream.
module tb_expr_tx;

  localparam int unsigned MAXN = 8;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [3:0]  cnt;
  logic [31:0] digits;
  logic [6:0]  ops;
  logic        ready;
  logic [7:0]  out;
  logic        valid;
  logic        busy;
  logic        done;
  logic        err;

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  logic [7:0]  exp_q[$];

  // Monitor-private state
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_out = 8'h00;
  bit          rec_bad = 1'b0;
  bit          rec_want_dig = 1'b1;
  int          rec_len = 0;
  logic [7:0]  exp_ch;

  expr_tx #(.MAXN(MAXN)) dut (
    .clk    (clk),
    .clr    (clr),
    .start  (start),
    .cnt    (cnt),
    .digits (digits),
    .ops    (ops),
    .ready  (ready),
    .out    (out),
    .valid  (valid),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push_model(input int n, input logic [31:0] d, input logic [6:0] o);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(8'h30 + {4'h0, d[4*i +: 4]});
      if (i < n - 1) exp_q.push_back(o[i] ? 8'h2A : 8'h2B);
    end
  endtask

  // Runs one accepted stream; pat gives per-cycle ready from the first character cycle.
  task automatic do_stream(input int n, input logic [31:0] d, input logic [6:0] o,
                           input logic [15:0] pat, input int plen, input bit mess,
                           input int exp_lat);
    int cyc;
    int k;
    cyc = 1;
    k = 0;
    @(posedge clk); #1;
    cnt = 4'(n); digits = d; ops = o; start = 1'b1; ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (mess) begin
      start = 1'b1; digits = ~d; ops = ~o; cnt = 4'd1;
    end
    forever begin
      ready = (k < plen) ? pat[k] : 1'b1;
      @(negedge clk);
      cyc++;
      if (done) break;
      if (cyc > 60) begin
        checks++; errors++;
        $display("FAIL stream_timeout: got no done after %0d cycles, required done", cyc);
        break;
      end
      @(posedge clk); #1;
      start = 1'b0;
      k++;
    end
    check("latency", cyc, exp_lat);
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 0);
    check("idle_after_done", {31'd0, busy}, 0);
  endtask

  task automatic do_reject(input int n, input logic [31:0] d);
    @(posedge clk); #1;
    cnt = 4'(n); digits = d; start = 1'b1; ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("err_pulse", {31'd0, err}, 1);
    check("err_valid", {31'd0, valid}, 0);
    check("err_busy", {31'd0, busy}, 0);
    @(negedge clk);
    check("err_single", {31'd0, err}, 0);
    check("err_busy_after", {31'd0, busy}, 0);
  endtask

  // Monitor: scoreboard pop, hold-while-stalled, idle output and recogniser on every negedge
  initial begin
    forever begin
      @(negedge clk);
      if (clr) begin
        prev_stall = 1'b0; rec_bad = 1'b0; rec_want_dig = 1'b1; rec_len = 0;
        continue;
      end
      if (prev_stall) begin
        check("hold_valid", {31'd0, valid}, 1);
        check("hold_out", {24'd0, out}, {24'd0, prev_out});
      end
      if (!valid) check("idle_out", {24'd0, out}, 0);
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_char: got %0h expected no character", out);
        end else begin
          exp_ch = exp_q.pop_front();
          check("stream_char", {24'd0, out}, {24'd0, exp_ch});
        end
        if (rec_want_dig) begin
          if (out >= 8'h30 && out <= 8'h39) rec_want_dig = 1'b0;
          else rec_bad = 1'b1;
        end else begin
          if (out == 8'h2B || out == 8'h2A) rec_want_dig = 1'b1;
          else rec_bad = 1'b1;
        end
        rec_len++;
      end
      if (done) begin
        check("done_valid", {31'd0, valid}, 0);
        check("done_drained", exp_q.size(), 0);
        check("recogniser", {31'd0, (!rec_bad && !rec_want_dig && rec_len > 0)}, 1);
        rec_bad = 1'b0; rec_want_dig = 1'b1; rec_len = 0;
        done_cnt++;
      end
      prev_stall = valid && !ready;
      prev_out = out;
    end
  end

  initial begin
    int snap;
    logic [31:0] d;
    logic [6:0] o;
    clr = 1'b1; start = 1'b0; ready = 1'b0; cnt = 4'd0; digits = '0; ops = '0;
    #1;
    check("rst_valid", {31'd0, valid}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_err", {31'd0, err}, 0);
    check("rst_out", {24'd0, out}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr = 1'b0;

    // Scenario 1: "2+7*4", done at cycle 7
    exp_q.push_back(8'h32); exp_q.push_back(8'h2B); exp_q.push_back(8'h37);
    exp_q.push_back(8'h2A); exp_q.push_back(8'h34);
    do_stream(3, 32'h472, 7'b0000010, 16'h0, 0, 1'b0, 7);

    // Scenario 2: single digit 9
    exp_q.push_back(8'h39);
    do_stream(1, 32'h9, 7'h0, 16'h0, 0, 1'b0, 3);

    // Scenario 3: ready 1,0,0,1,1 with mid-stream input churn and an ignored start
    exp_q.push_back(8'h31); exp_q.push_back(8'h2B); exp_q.push_back(8'h36);
    do_stream(2, 32'h61, 7'h0, 16'b11001, 5, 1'b1, 7);

    // Scenario 4: rejected starts; digit >9 only in an unused slot is legal
    do_reject(0, 32'h123);
    do_reject(9, 32'h12345678);
    do_reject(3, 32'hA12);
    exp_q.push_back(8'h35); exp_q.push_back(8'h2B); exp_q.push_back(8'h33);
    do_stream(2, 32'hA35, 7'h0, 16'h0, 0, 1'b0, 5);

    // Scenario 5: clr after two characters, then restart from d0
    snap = done_cnt;
    push_model(3, 32'h583, 7'b0000010);
    @(posedge clk); #1;
    cnt = 4'd3; digits = 32'h583; ops = 7'b0000010; start = 1'b1; ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    clr = 1'b1;
    exp_q.delete();
    #1;
    check("clr_valid", {31'd0, valid}, 0);
    check("clr_busy", {31'd0, busy}, 0);
    check("clr_out", {24'd0, out}, 0);
    check("clr_done", {31'd0, done}, 0);
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    exp_q.push_back(8'h34); exp_q.push_back(8'h2A); exp_q.push_back(8'h32);
    cnt = 4'd2; digits = 32'h24; ops = 7'b0000001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("restart_busy", {31'd0, busy}, 1);
    check("restart_first", {24'd0, out}, 32'h34);
    repeat (5) @(posedge clk);
    #1;
    check("no_done_after_clr", done_cnt, snap + 1);
    check("restart_drained", exp_q.size(), 0);

    // Scenario 6: every operand count with random digits and operators
    for (int n = 1; n <= 8; n++) begin
      d = $urandom;
      for (int i = 0; i < n; i++) d[4*i +: 4] = 4'($urandom_range(0, 9));
      o = 7'($urandom);
      push_model(n, d, o);
      do_stream(n, d, o, 16'h0, 0, 1'b0, 2 * n + 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/expr_tx.md
EXPR_TX -- requirements
Module: expr_tx

Interface
REQ-001 The block SHALL have parameter MAXN, default 8, the maximum operand count (2..8).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port clr  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port start  input  1  request to serialise one expression; sampled only in IDLE.
REQ-005 The block SHALL have port cnt  input  4  operand count n, legal 1..MAXN.
REQ-006 The block SHALL have port digits  input  4*MAXN  operand i in bits [4i+3:4i], BCD.
REQ-007 The block SHALL have port ops  input  MAXN-1  operator i after operand i: 0='+', 1='*'.
REQ-008 The block SHALL have port ready  input  1  downstream accepts out this cycle.
REQ-009 The block SHALL have port out  output  8  ASCII character.
REQ-010 The block SHALL have port valid  output  1  out holds a character.
REQ-011 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 The block SHALL have port done  output  1  one-cycle pulse after the last character is accepted.
REQ-013 The block SHALL have port err  output  1  one-cycle pulse when a start is rejected.

Function
REQ-014 The block SHALL emit only strings a downstream expression recogniser accepts: d0 op0 d1 op1 ... d(n-1), length 2n-1, digit first and last.
REQ-015 The block SHALL implement the states IDLE, DIG, OP and FIN.
REQ-016 The IDLE transition on start SHALL register cnt, digits and ops, and SHALL go to DIG with index 0 on the next edge.
REQ-017 If cnt=0, cnt>MAXN or any used digit >9, the block SHALL instead pulse err for one cycle, emit nothing and stay in IDLE.
REQ-018 In DIG the block SHALL drive out=8'h30+digit[idx] with valid=1.
REQ-019 In OP the block SHALL drive out=8'h2B ('+') or 8'h2A ('*') per ops[idx-1] with valid=1.
REQ-020 A character SHALL be transferred only on a cycle with valid&&ready.
REQ-021 While valid&&!ready, out SHALL hold stable.
REQ-022 On a DIG transfer the block SHALL go to OP and increment idx, or go to FIN if idx=n-1.
REQ-023 On an OP transfer the block SHALL go to DIG.
REQ-024 Back-to-back transfers SHALL be supported, giving 1 character per cycle while ready=1.
REQ-025 FIN SHALL assert done=1 with valid=0 for exactly one cycle, then go to IDLE; start is ignored in FIN.
REQ-026 The first character SHALL appear (valid=1) one cycle after start is accepted.
REQ-027 Total start-to-done latency with ready held high SHALL be 2n+1 cycles.
REQ-028 Start asserted while busy SHALL be ignored; registered operands SHALL be immune to input changes mid-stream.
REQ-029 Outside DIG/OP, valid SHALL be 0 and out SHALL be 8'h00.
REQ-030 idx SHALL be 3 bits and SHALL never exceed n-1; no wrap-around is possible.

Reset
REQ-031 clr=1 SHALL, asynchronously and at any time including mid-stream, force state=IDLE, idx=0, out=8'h00, valid=0, busy=0, done=0 and err=0.
REQ-032 A stream interrupted by reset SHALL be abandoned; no done pulse is produced.
REQ-033 After clr is released, the first start SHALL be honoured on the next rising clk edge.

Structure
REQ-034 The shared package expr_pkg SHALL hold the state encoding (IDLE=0, DIG=1, OP=2, FIN=3) and the ASCII constants CH_ZERO=8'h30, CH_PLUS=8'h2B, CH_STAR=8'h2A.
REQ-035 The sub-module expr_char_enc SHALL be combinational, mapping (is_op, op_bit, digit) to an 8-bit ASCII value.
REQ-036 The FSM, capture registers and handshake SHALL stay in expr_tx.

Verification
REQ-037 Scenario 1: cnt=3, digits={..,4,7,2}, ops=2'b10, ready=1 -> the stream SHALL be "2+7*4" (32 2B 37 2A 34) on consecutive cycles and done SHALL pulse at cycle 7.
REQ-038 Scenario 2: cnt=1, digit 9 -> the stream SHALL be the single character 8'h39 followed by done the next cycle.
REQ-039 Scenario 3: cnt=2 with ready toggling 1,0,0,1,1 -> each character SHALL be held while ready=0 and the stream SHALL be "d+d" with no loss or duplication.
REQ-040 Scenario 4: digit 4'hA in a used slot, or cnt=0 -> err SHALL pulse once, valid SHALL stay 0 and busy SHALL stay 0.
REQ-041 Scenario 5: clr asserted mid-stream after 2 characters -> outputs SHALL clear immediately with no done; a new start SHALL stream from d0.
REQ-042 Scenario 6: the output stream fed to the expression recogniser for all 8 operand counts with random ops -> the recogniser output SHALL be 1 after the final character.
